// File: rtl/delay_line_pkg.sv
// Shared types and default sizing for the programmable delay line.
package delay_line_pkg;

  // Control FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } dl_state_t;

  localparam int DEF_W         = 8;
  localparam int DEF_MAX_DELAY = 256;

endpackage : delay_line_pkg

// File: rtl/delay_line_mem.sv
// Sample storage: DEPTH x W, synchronous write, asynchronous read.
// Because the read is combinational, a read of the address being written in
// the same cycle returns the previous contents (read-before-write).
module delay_line_mem #(
  parameter int W     = 8,
  parameter int DEPTH = 256,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data
);

  logic [W-1:0] mem [DEPTH];

  // Write port; storage is deliberately left unreset
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule : delay_line_mem

// File: rtl/programmable_delay_line.sv
// Programmable delay line: delays a strobed sample stream by a programmable
// number of accepted samples (not cycles), using a circular buffer.
module programmable_delay_line
  import delay_line_pkg::*;
#(
  parameter int W         = DEF_W,
  parameter int MAX_DELAY = DEF_MAX_DELAY,
  parameter int DW        = $clog2(MAX_DELAY + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [DW-1:0] delay,
  input  logic          in_valid,
  input  logic [W-1:0]  in_data,
  output logic          out_valid,
  output logic [W-1:0]  out_data,
  output logic          busy,
  output logic          delay_ovf
);

  localparam int AW  = $clog2(MAX_DELAY);
  localparam int DW1 = DW + 1;
  localparam logic [DW-1:0] ONE = DW'(1);

  dl_state_t     state, state_nx;
  logic [AW-1:0] wr_ptr, wr_ptr_nx;
  logic [DW-1:0] fill_cnt, fill_cnt_nx;
  logic [DW-1:0] delay_q, delay_q_nx;
  logic          out_valid_nx;
  logic [W-1:0]  out_data_nx;
  logic          delay_ovf_nx;

  logic          req_ovf;
  logic [DW-1:0] dly_c;
  logic          we;
  logic [AW-1:0] rd_addr;
  logic [W-1:0]  rd_data;

  // Advance the write pointer modulo MAX_DELAY
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    if (p == AW'(MAX_DELAY - 1)) begin
      return '0;
    end
    return p + 1'b1;
  endfunction

  // Read address = (wr_ptr - dly) mod MAX_DELAY, dly in [0, MAX_DELAY]
  function automatic logic [AW-1:0] rd_addr_of(input logic [AW-1:0] p,
                                               input logic [DW-1:0] dly);
    logic [DW1-1:0] pw;
    logic [DW1-1:0] dw;
    logic [DW1-1:0] diff;
    pw = DW1'(p);
    dw = DW1'(dly);
    if (pw >= dw) begin
      diff = pw - dw;
    end else begin
      diff = pw + DW1'(MAX_DELAY) - dw;
    end
    return AW'(diff);
  endfunction

  assign req_ovf = (delay > DW'(MAX_DELAY));
  assign dly_c   = req_ovf ? DW'(MAX_DELAY) : delay;
  assign rd_addr = rd_addr_of(wr_ptr, delay_q);
  assign busy    = (state == FILL);

  delay_line_mem #(
    .W     (W),
    .DEPTH (MAX_DELAY),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .we      (we),
    .wr_addr (wr_ptr),
    .wr_data (in_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // Control and output registers; buffer contents are never reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      fill_cnt  <= '0;
      delay_q   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      delay_ovf <= 1'b0;
    end else begin
      state     <= state_nx;
      wr_ptr    <= wr_ptr_nx;
      fill_cnt  <= fill_cnt_nx;
      delay_q   <= delay_q_nx;
      out_valid <= out_valid_nx;
      out_data  <= out_data_nx;
      delay_ovf <= delay_ovf_nx;
    end
  end

  // Next-state, buffer write and output selection
  always_comb begin
    state_nx     = state;
    wr_ptr_nx    = wr_ptr;
    fill_cnt_nx  = fill_cnt;
    delay_q_nx   = delay_q;
    out_valid_nx = 1'b0;
    out_data_nx  = out_data;
    delay_ovf_nx = delay_ovf | req_ovf;
    we           = 1'b0;

    if (!en) begin
      state_nx = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          // Buffer is stale here: always refill when a nonzero delay is used
          delay_q_nx  = dly_c;
          fill_cnt_nx = '0;
          state_nx    = (dly_c == '0) ? RUN : FILL;
        end
        default: begin
          we = in_valid;
          if (in_valid) begin
            wr_ptr_nx = ptr_inc(wr_ptr);
          end
          if (dly_c != delay_q) begin
            // Delay changed: any same-cycle strobe is the first fill strobe
            delay_q_nx = dly_c;
            if (dly_c == '0 || (in_valid && dly_c == ONE)) begin
              state_nx = RUN;
            end else begin
              state_nx    = FILL;
              fill_cnt_nx = in_valid ? ONE : '0;
            end
          end else if (state == FILL) begin
            if (in_valid) begin
              if (fill_cnt == delay_q - ONE) begin
                state_nx = RUN;
              end else begin
                fill_cnt_nx = fill_cnt + ONE;
              end
            end
          end else if (in_valid) begin
            // Zero delay bypasses the buffer, which would return old data
            out_valid_nx = 1'b1;
            out_data_nx  = (delay_q == '0) ? in_data : rd_data;
          end
        end
      endcase
    end
  end

endmodule : programmable_delay_line

// File: tb/tb_programmable_delay_line.sv
// Directed testbench for programmable_delay_line (W=8, MAX_DELAY=16).
module tb_programmable_delay_line;

  localparam int W         = 8;
  localparam int MAX_DELAY = 16;
  localparam int DW        = $clog2(MAX_DELAY + 1);

  logic          clk;
  logic          rst_n;
  logic          en;
  logic [DW-1:0] delay;
  logic          in_valid;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic          busy;
  logic          delay_ovf;

  int   n_chk;
  int   n_fail;
  logic busy_pre;

  programmable_delay_line #(
    .W         (W),
    .MAX_DELAY (MAX_DELAY)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .delay     (delay),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_data  (out_data),
    .busy      (busy),
    .delay_ovf (delay_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One cycle: drive inputs, capture busy before the edge, sample after it
  task automatic step(input logic v, input logic [W-1:0] d);
    in_valid = v;
    in_data  = d;
    #1;
    busy_pre = busy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int gap;
    n_chk    = 0;
    n_fail   = 0;
    busy_pre = 1'b0;
    rst_n    = 1'b1;
    en       = 1'b0;
    delay    = '0;
    in_valid = 1'b0;
    in_data  = '0;

    // Reset values
    #2 rst_n = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data",  32'(out_data),  32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_delay_ovf", 32'(delay_ovf), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Delay 3, values 1..10
    delay = DW'(3);
    en    = 1'b1;
    step(1'b0, '0);
    for (int i = 1; i <= 10; i++) begin
      step(1'b1, W'(i));
      check("d3_busy", 32'(busy_pre), (i <= 3) ? 32'd1 : 32'd0);
      check("d3_valid", 32'(out_valid), (i <= 3) ? 32'd0 : 32'd1);
      if (i > 3) check("d3_data", 32'(out_data), 32'(i - 3));
    end
    step(1'b0, 8'hFF);
    check("d3_gap_valid", 32'(out_valid), 32'd0);
    check("d3_gap_hold",  32'(out_data),  32'd7);

    // Disable, then zero delay pass-through
    en = 1'b0;
    step(1'b0, '0);
    check("idle_valid", 32'(out_valid), 32'd0);
    delay = '0;
    en    = 1'b1;
    step(1'b0, '0);
    step(1'b1, 8'hA5);
    check("d0_busy",   32'(busy_pre),  32'd0);
    check("d0_valid0", 32'(out_valid), 32'd1);
    check("d0_data0",  32'(out_data),  32'hA5);
    step(1'b1, 8'h3C);
    check("d0_busy1",  32'(busy_pre),  32'd0);
    check("d0_valid1", 32'(out_valid), 32'd1);
    check("d0_data1",  32'(out_data),  32'h3C);

    // Full depth with gaps and pointer wrap
    en = 1'b0;
    step(1'b0, '0);
    delay = DW'(16);
    en    = 1'b1;
    step(1'b0, '0);
    for (int i = 1; i <= 40; i++) begin
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        step(1'b0, 8'hEE);
        check("d16_gap_valid", 32'(out_valid), 32'd0);
      end
      step(1'b1, W'(i));
      check("d16_valid", 32'(out_valid), (i <= 16) ? 32'd1 - 32'd1 : 32'd1);
      if (i > 16) check("d16_data", 32'(out_data), 32'(i - 16));
    end

    // Delay change 3 -> 5 at strobe 20
    en = 1'b0;
    step(1'b0, '0);
    delay = DW'(3);
    en    = 1'b1;
    step(1'b0, '0);
    for (int i = 1; i <= 30; i++) begin
      if (i == 20) delay = DW'(5);
      step(1'b1, W'(i));
      if (i <= 3 || (i >= 20 && i <= 24)) begin
        check("chg_valid_lo", 32'(out_valid), 32'd0);
      end else begin
        check("chg_valid_hi", 32'(out_valid), 32'd1);
        check("chg_data", 32'(out_data), (i < 20) ? 32'(i - 3) : 32'(i - 5));
      end
    end

    // Over-range delay is clamped and sticky
    en    = 1'b0;
    delay = DW'(20);
    step(1'b0, '0);
    check("ovf_set", 32'(delay_ovf), 32'd1);
    en = 1'b1;
    step(1'b0, '0);
    for (int i = 1; i <= 20; i++) begin
      step(1'b1, W'(i));
      check("ovf_valid", 32'(out_valid), (i <= 16) ? 32'd0 : 32'd1);
      if (i > 16) check("ovf_data", 32'(out_data), 32'(i - 16));
    end
    delay = DW'(4);
    for (int i = 21; i <= 25; i++) begin
      step(1'b1, W'(i));
      check("ovf_sticky", 32'(delay_ovf), 32'd1);
      check("d4_valid", 32'(out_valid), (i <= 24) ? 32'd0 : 32'd1);
    end
    check("d4_data", 32'(out_data), 32'd21);

    // Asynchronous reset mid-run
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_data",  32'(out_data),  32'd0);
    check("arst_ovf",   32'(delay_ovf), 32'd0);
    check("arst_busy",  32'(busy),      32'd0);
    #2 rst_n = 1'b1;
    delay = DW'(2);
    step(1'b0, '0);
    step(1'b1, 8'd101);
    check("rs_busy0",  32'(busy_pre),  32'd1);
    check("rs_valid0", 32'(out_valid), 32'd0);
    step(1'b1, 8'd102);
    check("rs_busy1",  32'(busy_pre),  32'd1);
    check("rs_valid1", 32'(out_valid), 32'd0);
    step(1'b1, 8'd103);
    check("rs_valid2", 32'(out_valid), 32'd1);
    check("rs_data2",  32'(out_data),  32'd101);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule : tb_programmable_delay_line
